// File: rtl/multdiv_sequencer_if.sv
// Bundle between the execute stage, the multdiv sequencer and the iterative multdiv unit.
interface multdiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             op_is_div;
  logic [WIDTH-1:0] op_A;
  logic [WIDTH-1:0] op_B;
  logic             flush;
  logic             md_ctrl_MULT;
  logic             md_ctrl_DIV;
  logic [WIDTH-1:0] md_operandA;
  logic [WIDTH-1:0] md_operandB;
  logic [WIDTH-1:0] md_result;
  logic             md_exception;
  logic             md_ready;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic             timeout;
  logic             busy;
  logic             done;

  modport master (
    output op_valid, op_is_div, op_A, op_B, flush, md_result, md_exception, md_ready,
    input  md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB, stall, result,
           exception, timeout, busy, done
  );

  modport slave (
    input  op_valid, op_is_div, op_A, op_B, flush, md_result, md_exception, md_ready,
    output md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB, stall, result,
           exception, timeout, busy, done
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Start-pulse / stall controller for the iterative multdiv unit, with flush and watchdog.
//   state | meaning
//   IDLE  | no operation; accepts op_valid when not flushed
//   ISSUE | one-cycle start pulse, watchdog cleared
//   WAIT  | stalled until md_ready or watchdog limit
//   DONE  | one-cycle advance with held result/exception
module multdiv_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic                clock,
  input  logic                reset,
  multdiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             tmo_q;

  logic accept_d;
  logic wdog_d;

  assign accept_d = (state_q == IDLE) && bus.op_valid && !bus.flush;
  assign wdog_d   = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            opa_q    <= bus.op_A;
            opb_q    <= bus.op_B;
            is_div_q <= bus.op_is_div;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= bus.flush ? IDLE : WAIT;
        end
        WAIT: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else if (bus.md_ready) begin
            result_q <= bus.md_result;
            exc_q    <= bus.md_exception;
            tmo_q    <= 1'b0;
            state_q  <= DONE;
          end else if (wdog_d) begin
            result_q <= '0;
            exc_q    <= 1'b1;
            tmo_q    <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Everything is forced low while reset is held, even before the reset edge lands.
  assign bus.stall        = !reset && !bus.flush &&
                            (((state_q == IDLE) && bus.op_valid) ||
                             (state_q == ISSUE) || (state_q == WAIT));
  assign bus.md_ctrl_MULT = !reset && (state_q == ISSUE) && !is_div_q;
  assign bus.md_ctrl_DIV  = !reset && (state_q == ISSUE) && is_div_q;
  assign bus.busy         = !reset && (state_q != IDLE);
  assign bus.done         = !reset && (state_q == DONE);
  assign bus.md_operandA  = reset ? '0 : opa_q;
  assign bus.md_operandB  = reset ? '0 : opb_q;
  assign bus.result       = reset ? '0 : result_q;
  assign bus.exception    = !reset && exc_q;
  assign bus.timeout      = !reset && tmo_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench: the driver plays X stage and multdiv unit, a monitor checks every done strobe.
module tb_multdiv_sequencer;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 6;
  localparam int M_NORM  = 0;
  localparam int M_TMO   = 1;
  localparam int M_FLUSH = 2;
  localparam int M_RST   = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  multdiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  multdiv_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int               at;
    logic [WIDTH-1:0] res;
    logic             exc;
    logic             tmo;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] last_res = '0;
  logic             last_exc = 1'b0;
  logic             last_tmo = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctl"}, {bus.stall, bus.md_ctrl_MULT, bus.md_ctrl_DIV, bus.exception,
                         bus.timeout, bus.busy, bus.done}, 0);
    chk({name, "_opA"}, bus.md_operandA, 0);
    chk({name, "_opB"}, bus.md_operandB, 0);
    chk({name, "_res"}, bus.result, 0);
  endtask

  // Reference: what a correct multdiv unit returns, and what the watchdog forces.
  function automatic exp_t model(input bit is_div, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input int mode, input int at);
    exp_t e;
    e.at  = at;
    e.tmo = 1'b0;
    if (mode == M_TMO) begin
      e.res = '0; e.exc = 1'b1; e.tmo = 1'b1;
    end else if (is_div) begin
      if (b == 0) begin e.res = '0; e.exc = 1'b1; end
      else begin e.res = a / b; e.exc = 1'b0; end
    end else begin
      e.res = a * b; e.exc = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    chk("start_mutex", {63'b0, bus.md_ctrl_MULT & bus.md_ctrl_DIV}, 0);
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("done_result", bus.result, e.res);
        chk("done_exception", bus.exception, e.exc);
        chk("done_timeout", bus.timeout, e.tmo);
        chk("done_stall", bus.stall, 0);
      end
    end
  end

  // Starts at posedge+1 of an IDLE cycle, ends at the negedge of DONE (or after an abort).
  task automatic do_op(input bit is_div, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int mode, input int n);
    int   c0;
    int   nw;
    exp_t e;
    c0 = cyc;
    nw = (mode == M_TMO) ? TIMEOUT : n;
    e  = model(is_div, a, b, mode, c0 + 2 + nw);
    if (mode == M_NORM || mode == M_TMO) sb.push_back(e);
    bus.op_valid = 1'b1; bus.op_is_div = is_div; bus.op_A = a; bus.op_B = b;
    bus.flush = 1'b0; bus.md_ready = 1'b0;
    @(negedge clock);
    chk("accept_stall", bus.stall, 1);
    chk("accept_busy", bus.busy, 0);

    step();
    bus.md_ready     = 1'($urandom_range(0, 1));
    bus.md_result    = $urandom;
    bus.md_exception = 1'($urandom_range(0, 1));
    bus.op_A = $urandom; bus.op_B = $urandom;
    @(negedge clock);
    chk("issue_mult", bus.md_ctrl_MULT, !is_div);
    chk("issue_div", bus.md_ctrl_DIV, is_div);
    chk("issue_opA", bus.md_operandA, a);
    chk("issue_opB", bus.md_operandB, b);
    chk("issue_stall", bus.stall, 1);

    for (int w = 1; w <= nw; w++) begin
      step();
      bus.md_ready     = (mode == M_NORM) && (w == nw);
      bus.md_result    = bus.md_ready ? e.res : WIDTH'($urandom);
      bus.md_exception = bus.md_ready ? e.exc : 1'($urandom_range(0, 1));
      bus.flush        = (mode == M_FLUSH) && (w == nw);
      reset            = (mode == M_RST) && (w == nw);
      @(negedge clock);
      if (mode == M_RST && w == nw) begin
        chk_zero("rst_mid");
      end else begin
        chk("wait_stall", bus.stall, !((mode == M_FLUSH) && (w == nw)));
        chk("wait_start", {bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 0);
        chk("wait_opA", bus.md_operandA, a);
        chk("wait_opB", bus.md_operandB, b);
      end
    end

    step();
    bus.md_ready = 1'b0; bus.flush = 1'b0; reset = 1'b0;
    bus.md_result = $urandom;
    if (mode == M_NORM || mode == M_TMO) begin
      @(negedge clock);
      chk("done_flag", bus.done, 1);
      chk("done_busy", bus.busy, 1);
      chk("done_opA", bus.md_operandA, a);
      last_res = e.res; last_exc = e.exc; last_tmo = e.tmo;
    end else begin
      bus.op_valid = 1'b0;
      if (mode == M_RST) begin last_res = '0; last_exc = 1'b0; last_tmo = 1'b0; end
      @(negedge clock);
      chk("abort_busy", bus.busy, 0);
      chk("abort_stall", bus.stall, 0);
      chk("abort_result", bus.result, last_res);
      chk("abort_exception", bus.exception, last_exc);
      chk("abort_timeout", bus.timeout, last_tmo);
      step();
      bus.md_ready = 1'b1; bus.md_result = $urandom; bus.md_exception = 1'b1;
      @(negedge clock);
      chk("late_ready_busy", bus.busy, 0);
      chk("late_ready_result", bus.result, last_res);
    end
  endtask

  task automatic idle();
    step();
    bus.op_valid = 1'b0; bus.flush = 1'b0; bus.md_ready = 1'b0;
    @(negedge clock);
    chk("idle_stall", bus.stall, 0);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    bus.op_valid = 1'b0; bus.op_is_div = 1'b0; bus.op_A = '0; bus.op_B = '0;
    bus.flush = 1'b0; bus.md_result = '0; bus.md_exception = 1'b0; bus.md_ready = 1'b0;
    bus.op_valid = 1'b1; bus.md_ready = 1'b1;
    repeat (3) begin
      step();
      @(negedge clock);
      chk_zero("reset");
    end
    step();
    reset = 1'b0; bus.op_valid = 1'b0; bus.md_ready = 1'b0;
    @(negedge clock);
    chk_zero("post_reset");

    step(); do_op(1'b0, 7, 6, M_NORM, 32);
    idle();
    step(); do_op(1'b1, 100, 0, M_NORM, 20);
    step(); do_op(1'b0, 3, 4, M_NORM, 15);
    step(); do_op(1'b1, 20, 5, M_NORM, 9);
    idle();
    step(); do_op(1'b0, 0, 0, M_TMO, 0);
    step(); do_op(1'b0, 5, 5, M_NORM, 3);
    step(); do_op(1'b0, 7, 6, M_NORM, 10);
    step(); do_op(1'b1, 9, 3, M_FLUSH, 5);
    step(); do_op(1'b0, 1, 1, M_NORM, TIMEOUT);
    step(); do_op(1'b1, 50, 7, M_NORM, 1);

    step();
    bus.op_valid = 1'b1; bus.flush = 1'b1; bus.md_ready = 1'b0;
    @(negedge clock);
    chk("idle_flush_stall", bus.stall, 0);
    step();
    bus.op_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clock);
    chk("idle_flush_busy", bus.busy, 0);

    step(); do_op(1'b0, 9, 9, M_RST, 4);
    step(); do_op(1'b0, 2, 2, M_NORM, 6);

    for (int i = 0; i < 30; i++) begin
      int               r;
      int               mode;
      bit               is_div;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      r      = $urandom_range(0, 9);
      mode   = (r < 7) ? M_NORM : (r == 7) ? M_TMO : (r == 8) ? M_FLUSH : M_RST;
      is_div = 1'($urandom_range(0, 1));
      a      = $urandom;
      b      = is_div ? (($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom_range(1, 1000)))
                      : WIDTH'($urandom);
      if ($urandom_range(0, 1) == 1) idle();
      step();
      do_op(is_div, a, b, mode, $urandom_range(1, TIMEOUT));
    end
    idle();
    idle();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
